// File: rtl/mem_if_pkg.sv
`default_nettype none
// ============================================================================
// mem_if_pkg : shared state encoding and parameter defaults for mem_interface
// Revision   : 1.0
// ============================================================================
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_ADDR_W  = 9;
  localparam int DEF_TIMEOUT = 15;

endpackage
`default_nettype wire

// File: rtl/wait_timer.sv
`default_nettype none
// ============================================================================
// wait_timer : counts cycles spent waiting for mem_ack; expired marks the last
//              allowed wait cycle
// Revision   : 1.0
// ============================================================================
module wait_timer #(
  parameter int TIMEOUT = mem_if_pkg::DEF_TIMEOUT
) (
  input  logic clk,
  input  logic clr,
  input  logic start,
  input  logic tick,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // count is 0 in the first wait cycle, so LAST flags the TIMEOUT-th cycle
  assign expired = (count == LAST);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (tick && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_interface.sv
`default_nettype none
// ============================================================================
// mem_interface : MAR/MDR register pair with a read/write handshake FSM and
//                 a cycle-bounded wait for mem_ack
// Revision      : 1.0
// ============================================================================
module mem_interface
  import mem_if_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [31:0]       bus_in,
  input  logic              mar_load,
  input  logic              mdr_load,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mdr_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state;
  logic [ADDR_W-1:0] mar;
  logic [31:0]       mdr;
  logic              err_q;
  logic              timer_start;
  logic              expired;

  assign timer_start = (state == IDLE) && (rd_req || wr_req);

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .clr     (clr),
    .start   (timer_start),
    .tick    (busy),
    .expired (expired)
  );

  // Strobes come straight from the state register so reset kills them at once
  assign mem_rd    = (state == READ);
  assign mem_wr    = (state == WRITE);
  assign busy      = (state == READ) || (state == WRITE);
  assign done      = (state == DONE);
  assign err       = err_q;
  assign mem_addr  = mar;
  assign mem_wdata = mdr;
  assign mdr_out   = mdr;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      mar   <= '0;
      mdr   <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          err_q <= 1'b0;
          if (mar_load) mar <= bus_in[ADDR_W-1:0];
          if (mdr_load) mdr <= bus_in;
          if (rd_req)      state <= READ;
          else if (wr_req) state <= WRITE;
        end
        READ: begin
          if (mem_ack) begin
            mdr   <= mem_rdata;
            state <= DONE;
          end else if (expired) begin
            err_q <= 1'b1;
            state <= DONE;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            state <= DONE;
          end else if (expired) begin
            err_q <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_interface.md
MEM_INTERFACE -- requirements
Module: mem_interface

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 9, the memory address width.
REQ-002 The block SHALL have parameter TIMEOUT, default 15, the maximum wait cycles for mem_ack before abort.
REQ-003 The block SHALL have port clk, input, 1: the clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port clr, input, 1: the reset, asynchronous, active-low.
REQ-005 The block SHALL have port bus_in, input, 32: the datapath bus value.
REQ-006 The block SHALL have port mar_load, input, 1: load MAR from bus_in.
REQ-007 The block SHALL have port mdr_load, input, 1: load MDR from bus_in.
REQ-008 The block SHALL have port rd_req, input, 1: start a memory read.
REQ-009 The block SHALL have port wr_req, input, 1: start a memory write.
REQ-010 The block SHALL have port mem_rdata, input, 32: memory read data.
REQ-011 The block SHALL have port mem_ack, input, 1: memory completion strobe.
REQ-012 The block SHALL have port mem_addr, output, ADDR_W: the MAR value, always driven.
REQ-013 The block SHALL have port mem_wdata, output, 32: the MDR value, always driven.
REQ-014 The block SHALL have port mem_rd, output, 1: high throughout the READ state.
REQ-015 The block SHALL have port mem_wr, output, 1: high throughout the WRITE state.
REQ-016 The block SHALL have port mdr_out, output, 32: the MDR value, always driven to the bus.
REQ-017 The block SHALL have port busy, output, 1: high in READ or WRITE.
REQ-018 The block SHALL have port done, output, 1: high for exactly one cycle, in DONE.
REQ-019 The block SHALL have port err, output, 1: high with done only when the transfer timed out.

Function
REQ-020 The state machine SHALL have the states IDLE, READ, WRITE and DONE; mem_rd, mem_wr, busy and done SHALL be decoded from the state alone.
REQ-021 In IDLE, mar_load SHALL set MAR to bus_in[ADDR_W-1:0], and mdr_load SHALL set MDR to bus_in, at the next edge.
REQ-022 In IDLE, rd_req SHALL move the block to READ, and wr_req (with rd_req low) SHALL move it to WRITE, at the next edge.
REQ-023 When rd_req and wr_req are both high, the read SHALL win and the write SHALL be dropped, not queued.
REQ-024 A load issued in the same cycle as a request SHALL be applied, so the transfer uses the new MAR/MDR value.
REQ-025 If mdr_load and rd_req are both high, MDR SHALL be loaded and later overwritten by the read data.
REQ-026 In READ, mem_ack high at an edge SHALL capture mem_rdata into MDR and move the block to DONE.
REQ-027 In WRITE, mem_ack high at an edge SHALL move the block to DONE with MDR unchanged.
REQ-028 The wait counter SHALL clear on entering READ or WRITE and increment each cycle in those states.
REQ-029 After TIMEOUT cycles in READ or WRITE without mem_ack, the block SHALL go to DONE with err high and MDR unchanged.
REQ-030 mem_ack on the final allowed cycle SHALL take priority over the timeout.
REQ-031 DONE SHALL last one cycle and return to IDLE; err SHALL be high only in a timeout DONE.
REQ-032 mar_load, mdr_load, rd_req and wr_req SHALL be ignored outside IDLE, and mem_ack SHALL be ignored in IDLE and DONE.
REQ-033 The minimum latency SHALL be: rd_req sampled at edge n, mem_rd high after edge n, ack at edge n+1, done high after edge n+1, IDLE after edge n+2.

Reset
REQ-034 clr low SHALL immediately force IDLE and clear MAR, MDR, the wait counter and the err flag, regardless of clk.
REQ-035 While clr is low, all outputs SHALL be 0, including mem_rd and mem_wr mid-transfer, with no memory strobe glitch beyond reset assertion.
REQ-036 After clr deasserts, the first rising clk edge SHALL operate normally from IDLE.

Structure
REQ-037 Package mem_if_pkg SHALL hold the state enum (IDLE=0, READ=1, WRITE=2, DONE=3) and the ADDR_W and TIMEOUT defaults.
REQ-038 The wait counter SHALL be the sub-module wait_timer, with inputs clk, clr, start and tick, and output expired.
REQ-039 MAR, MDR and the FSM SHALL live in mem_interface.

Verification
REQ-040 Read scenario: mar_load with bus_in=0x0000_0042, then rd_req, ack after 2 cycles with mem_rdata=0xDEADBEEF -> mem_addr=0x042, mdr_out=0xDEADBEEF, done pulses once, err=0.
REQ-041 Write scenario: mdr_load with 0x1234_5678 and wr_req in the same cycle, ack after 1 cycle -> mem_wr high 1 cycle, mem_wdata=0x12345678, done pulses.
REQ-042 Timeout scenario: rd_req with no ack -> busy for 15 cycles, then done=err=1 for one cycle, MDR unchanged.
REQ-043 Simultaneous scenario: rd_req and wr_req together -> only mem_rd asserts; a second rd_req while busy is ignored.
REQ-044 Reset scenario: clr pulled low mid-READ -> mem_rd=0 and mdr_out=0 immediately, IDLE after release, late mem_ack ignored.
REQ-045 Boundary scenario: ack on the 15th wait cycle -> data captured, err=0.
